// File: rtl/queen_board_collector_pkg.sv
// Shared types for the eight-queen board collector.
// Board dimension, row word type and the collector FSM states.
package queen_pkg;

    localparam int N     = 8;
    localparam int CNT_W = $clog2(N);

    typedef logic [N-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COLLECT,
        PRESENT
    } state_e;

endpackage

// File: rtl/queen_board_collector_if.sv
// Solver request/capture and row replay signals of the board collector.
// master = solver/host side, slave = collector.
interface queen_board_collector_if;
    import queen_pkg::*;

    logic             go;
    logic             solver_ready;
    logic             solver_start;
    logic             in_valid;
    row_t             in_row;
    logic             busy;
    logic             board_ok;
    logic             out_valid;
    logic             out_ready;
    row_t             out_row;
    logic [CNT_W-1:0] out_idx;

    modport master (
        output go, solver_ready, in_valid, in_row, out_ready,
        input  solver_start, busy, board_ok, out_valid, out_row, out_idx
    );

    modport slave (
        input  go, solver_ready, in_valid, in_row, out_ready,
        output solver_start, busy, board_ok, out_valid, out_row, out_idx
    );

endinterface

// File: rtl/queen_board_collector_check.sv
// Incremental one-hot / column / diagonal conflict checker.
// err includes the row being accepted this cycle.
module queen_conflict_check
    import queen_pkg::*;
(
    input  logic clk,
    input  logic user_reset,
    input  logic clear,
    input  logic accept,
    input  row_t row,
    output logic err
);

    row_t col_q;
    row_t diag_l_q;
    row_t diag_r_q;
    logic err_q;
    logic onehot;
    logic bad;

    assign onehot = (row != '0) && ((row & (row - 1'b1)) == '0);
    assign bad    = !onehot || ((row & (col_q | diag_l_q | diag_r_q)) != '0);
    assign err    = err_q | (accept & bad);

    always_ff @(posedge clk) begin
        if (user_reset || clear) begin
            col_q    <= '0;
            diag_l_q <= '0;
            diag_r_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            col_q    <= col_q | row;
            diag_l_q <= (diag_l_q | row) << 1;
            diag_r_q <= (diag_r_q | row) >> 1;
            err_q    <= err_q | bad;
        end
    end

endmodule

// File: rtl/queen_board_collector.sv
// Captures one solved board from the solver and replays it row by row.
// Define QUEEN_CHECK_EN to build the conflict checker and board verdict.
module queen_board_collector
    import queen_pkg::*;
(
    input  logic                    clk,
    input  logic                    user_reset,
    queen_board_collector_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e           state_q;
    logic             start_q;
    logic             ok_q;
    logic             ovalid_q;
    row_t             orow_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] wr_q;
    logic [CNT_W-1:0] rd_q;
    row_t             mem_q [N];

    logic             clear;
    logic             accept;
    logic             xfer;
    logic [CNT_W-1:0] rd_d;

    assign clear  = (state_q == IDLE) && bus.go;
    assign accept = (state_q == COLLECT) && bus.in_valid;
    assign xfer   = ovalid_q && bus.out_ready;
    assign rd_d   = rd_q + 1'b1;

`ifdef QUEEN_CHECK_EN
    logic err;

    queen_conflict_check u_check (
        .clk        (clk),
        .user_reset (user_reset),
        .clear      (clear),
        .accept     (accept),
        .row        (bus.in_row),
        .err        (err)
    );
`endif

    always_ff @(posedge clk) begin
        if (user_reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            ok_q     <= 1'b0;
            ovalid_q <= 1'b0;
            orow_q   <= '0;
            idx_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        state_q <= REQ;
                        wr_q    <= '0;
                        ok_q    <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.solver_ready) begin
                        start_q <= 1'b1;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    start_q <= 1'b0;
                    if (bus.in_valid) begin
                        mem_q[wr_q] <= bus.in_row;
                        wr_q        <= wr_q + 1'b1;
                        if (wr_q == LAST) begin
                            state_q  <= PRESENT;
`ifdef QUEEN_CHECK_EN
                            ok_q     <= ~err;
`else
                            ok_q     <= 1'b1;
`endif
                            rd_q     <= '0;
                            ovalid_q <= 1'b1;
                            orow_q   <= mem_q[0];
                            idx_q    <= '0;
                        end
                    end
                end
                PRESENT: begin
                    if (xfer) begin
                        rd_q <= rd_d;
                        if (rd_q == LAST) begin
                            ovalid_q <= 1'b0;
                            state_q  <= IDLE;
`ifndef QUEEN_CHECK_EN
                            ok_q     <= 1'b0;
`endif
                        end else begin
                            orow_q <= mem_q[rd_d];
                            idx_q  <= rd_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.solver_start = start_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.board_ok     = ok_q;
    assign bus.out_valid    = ovalid_q;
    assign bus.out_row      = orow_q;
    assign bus.out_idx      = idx_q;

endmodule

// File: tb/tb_queen_board_collector.sv
// Directed-vector bench for queen_board_collector.
// Expectations follow QUEEN_CHECK_EN the same way the build does.
module tb_queen_board_collector;
    import queen_pkg::*;

    logic clk = 1'b0;
    logic user_reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    queen_board_collector_if bus ();

    queen_board_collector dut (
        .clk        (clk),
        .user_reset (user_reset),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] VALID = 64'h08_02_40_04_20_80_10_01;
    localparam logic [63:0] COLC  = 64'h08_02_40_04_20_80_01_01;
    localparam logic [63:0] DIAG  = 64'h08_02_40_04_20_80_02_01;
    localparam logic [63:0] TWO   = 64'h08_02_40_04_20_80_10_03;
    localparam logic [63:0] ZERO  = 64'h08_02_40_04_20_80_10_00;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ok_exp(input logic ok);
`ifdef QUEEN_CHECK_EN
        return ok;
`else
        return 1'b1;
`endif
    endfunction

    task automatic run_board(input logic [63:0] rows, input logic ok,
                             input int rdy_dly, input int gap_at,
                             input int stall_at);
        logic [7:0] r;
        bus.go = 1'b1;
        bus.solver_ready = (rdy_dly == 0);
        step();
        bus.go = 1'b0;
        chk("busy_req", 32'(bus.busy), 1);
        chk("ok_clr", 32'(bus.board_ok), 0);
        chk("start_lo", 32'(bus.solver_start), 0);
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            chk("start_wait", 32'(bus.solver_start), 0);
        end
        bus.solver_ready = 1'b1;
        step();
        chk("start_hi", 32'(bus.solver_start), 1);
        for (int i = 0; i < N; i++) begin
            if (i == gap_at) begin
                bus.in_valid = 1'b0;
                step();
                step();
                chk("gap_nvalid", 32'(bus.out_valid), 0);
            end
            r = rows[i*8 +: 8];
            bus.in_valid = 1'b1;
            bus.in_row = r;
            step();
            if (i == 0) chk("start_pulse", 32'(bus.solver_start), 0);
            if (i < N - 1) chk("no_early_valid", 32'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
        bus.in_row = '0;
        chk("ok_present", 32'(bus.board_ok), 32'(ok_exp(ok)));
        for (int i = 0; i < N; i++) begin
            r = rows[i*8 +: 8];
            chk("ovalid", 32'(bus.out_valid), 1);
            chk("oidx", 32'(bus.out_idx), i);
            chk("orow", 32'(bus.out_row), 32'(r));
            if (i == stall_at) begin
                bus.out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("hold_idx", 32'(bus.out_idx), i);
                    chk("hold_row", 32'(bus.out_row), 32'(r));
                end
                bus.out_ready = 1'b1;
            end
            step();
        end
        chk("ovalid_end", 32'(bus.out_valid), 0);
        chk("busy_end", 32'(bus.busy), 0);
`ifdef QUEEN_CHECK_EN
        chk("ok_hold", 32'(bus.board_ok), 32'(ok));
`else
        chk("ok_hold", 32'(bus.board_ok), 0);
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, 32'(bus.solver_start), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ok"}, 32'(bus.board_ok), 0);
        chk({tag, "_ovalid"}, 32'(bus.out_valid), 0);
        chk({tag, "_orow"}, 32'(bus.out_row), 0);
        chk({tag, "_oidx"}, 32'(bus.out_idx), 0);
    endtask

    initial begin
        bus.go = 1'b0;
        bus.solver_ready = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_row = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        user_reset = 1'b0;
        chk_zero("rst");

        run_board(VALID, 1'b1, 0, -1, -1);
        run_board(COLC, 1'b0, 0, -1, -1);
        run_board(DIAG, 1'b0, 0, -1, -1);
        run_board(TWO, 1'b0, 0, -1, -1);
        run_board(ZERO, 1'b0, 0, -1, -1);
        run_board(VALID, 1'b1, 5, 3, 4);

        // abort a capture after five rows
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_row = 8'h01;
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_busy", 32'(bus.busy), 1);
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        chk_zero("mid_rst");
        run_board(VALID, 1'b1, 0, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
